// File: rtl/fifo_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_ptr_ctrl
// Brief    : Async-FIFO write-side controller: binary/Gray write pointer,
//            read-pointer synchroniser, registered full flag and fill level.
//            Optional almost-full output with macro FIFO_WR_ALMOST_FULL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH   = 4
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  parameter int AF_THRESHOLD = 12
`endif
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] w_address,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full_flag,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic [ADDR_WIDTH:0]   w_level
);

  localparam int c_ptr_w = ADDR_WIDTH + 1;

  logic [c_ptr_w-1:0] r_wbin;
  logic [c_ptr_w-1:0] r_rq1;
  logic [c_ptr_w-1:0] r_rq2;
  logic [c_ptr_w-1:0] r_ptr_gray;
  logic [c_ptr_w-1:0] r_level;
  logic               r_full;

  logic               w_wr;
  logic [c_ptr_w-1:0] w_wbin_next;
  logic [c_ptr_w-1:0] w_gray_next;
  logic [c_ptr_w-1:0] w_rq2_bin;
  logic [c_ptr_w-1:0] w_level_next;
  logic               w_full_next;

  // Accept uses the registered flag so no read-domain path reaches the gate.
  assign w_wr        = w_inc && !r_full;
  assign w_wbin_next = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wr};
  assign w_gray_next = w_wbin_next ^ (w_wbin_next >> 1);

  always_comb begin
    w_rq2_bin = '0;
    w_rq2_bin[c_ptr_w-1] = r_rq2[c_ptr_w-1];
    for (int i = c_ptr_w - 2; i >= 0; i--) begin
      w_rq2_bin[i] = w_rq2_bin[i+1] ^ r_rq2[i];
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign w_full_next  = (w_gray_next == {~r_rq2[c_ptr_w-1], ~r_rq2[c_ptr_w-2],
                                         r_rq2[c_ptr_w-3:0]});
  assign w_level_next = w_wbin_next - w_rq2_bin;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wbin     <= '0;
      r_ptr_gray <= '0;
      r_rq1      <= '0;
      r_rq2      <= '0;
      r_full     <= 1'b0;
      r_level    <= '0;
    end else begin
      r_wbin     <= w_wbin_next;
      r_ptr_gray <= w_gray_next;
      r_rq1      <= rd_ptr_gray;
      r_rq2      <= r_rq1;
      r_full     <= w_full_next;
      r_level    <= w_level_next;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [c_ptr_w-1:0] c_af_thr = c_ptr_w'(AF_THRESHOLD);

  logic r_almost_full;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= c_af_thr);
    end
  end

  assign almost_full = r_almost_full;
`endif

  assign w_address  = r_wbin[ADDR_WIDTH-1:0];
  assign w_ptr_gray = r_ptr_gray;
  assign full_flag  = r_full;
  assign w_level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ptr_ctrl.sv
`default_nettype none
// Directed bench for fifo_wr_ptr_ctrl (addr_width=4): reset, fill, drain,
// wrap, held request and, with FIFO_WR_ALMOST_FULL_EN, almost-full.
module tb_fifo_wr_ptr_ctrl;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_inc;
  logic [4:0] rd_ptr_gray;
  logic [3:0] w_address;
  logic [4:0] w_ptr_gray;
  logic       full_flag;
  logic [4:0] w_level;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_wr_ptr_ctrl #(
    .ADDR_WIDTH   (4)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .AF_THRESHOLD (12)
`endif
  ) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_inc       (w_inc),
    .rd_ptr_gray (rd_ptr_gray),
    .w_address   (w_address),
    .w_ptr_gray  (w_ptr_gray),
    .full_flag   (full_flag),
`ifdef FIFO_WR_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .w_level     (w_level)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst_n     = 1'b0;
    w_inc       = 1'b0;
    rd_ptr_gray = 5'd0;
    tick();
    tick();
    w_rst_n = 1'b1;
  endtask

  // The Gray pointer must move by exactly one bit whenever it changes.
  logic [4:0] prev_gray;
  bit         prev_valid = 0;
  always @(negedge w_clk) begin
    if (!w_rst_n) begin
      prev_valid = 0;
    end else begin
      if (prev_valid && (w_ptr_gray !== prev_gray)) begin
        checks++;
        if ($countones(w_ptr_gray ^ prev_gray) != 1) begin
          failures++;
          $display("FAIL gray_one_bit got=%b prev=%b", w_ptr_gray, prev_gray);
        end
      end
      prev_gray  = w_ptr_gray;
      prev_valid = 1;
    end
  end

  task automatic check_all_zero(input string tag);
    checks++;
    if ({w_address, w_ptr_gray, full_flag, w_level} !== 15'd0) begin
      failures++;
      $display("FAIL %s addr=%0d gray=%b full=%b level=%0d required all 0",
               tag, w_address, w_ptr_gray, full_flag, w_level);
    end
`ifdef FIFO_WR_ALMOST_FULL_EN
    checks++;
    if (almost_full !== 1'b0) begin
      failures++;
      $display("FAIL %s almost_full got=%b exp=0", tag, almost_full);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_initial");
    w_inc = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (w_address !== 4'd3 || w_level !== 5'd3) begin
      failures++;
      $display("FAIL pre_reset addr=%0d level=%0d exp addr=3 level=3", w_address, w_level);
    end
    rd_ptr_gray = 5'b00110;
    #2 w_rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    tick();
    check_all_zero("reset_held");
    w_inc       = 1'b0;
    rd_ptr_gray = 5'd0;
    w_rst_n     = 1'b1;
    tick();
    w_inc = 1'b1;
    tick();
    w_inc = 1'b0;
    checks++;
    if (w_address !== 4'd1 || w_ptr_gray !== 5'b00001) begin
      failures++;
      $display("FAIL first_write addr=%0d gray=%b exp addr=1 gray=00001", w_address, w_ptr_gray);
    end
  endtask

  task automatic test_fill();
    do_reset();
    checks++;
    if (w_address !== 4'd0) begin
      failures++;
      $display("FAIL fill_start addr got=%0d exp=0", w_address);
    end
    w_inc = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [4:0] n;
      n = (k >= 16) ? 5'd16 : 5'(k);
      tick();
      checks++;
      if (w_address !== n[3:0] || w_level !== n || w_ptr_gray !== gray(n) ||
          full_flag !== (k >= 16)) begin
        failures++;
        $display("FAIL fill_%0d addr=%0d level=%0d gray=%b full=%b exp addr=%0d level=%0d gray=%b full=%b",
                 k, w_address, w_level, w_ptr_gray, full_flag, n[3:0], n, gray(n), (k >= 16));
      end
    end
    checks++;
    if (w_ptr_gray !== 5'b11000) begin
      failures++;
      $display("FAIL fill_ignored gray got=%b exp=11000", w_ptr_gray);
    end
  endtask

  task automatic test_drain();
    w_inc       = 1'b0;
    rd_ptr_gray = 5'b00110;
    tick();
    tick();
    checks++;
    if (full_flag !== 1'b1 || w_level !== 5'd16) begin
      failures++;
      $display("FAIL drain_2 full=%b level=%0d exp full=1 level=16", full_flag, w_level);
    end
    tick();
    checks++;
    if (full_flag !== 1'b0 || w_level !== 5'd12) begin
      failures++;
      $display("FAIL drain_3 full=%b level=%0d exp full=0 level=12", full_flag, w_level);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] wb;
    wb    = 5'd16;
    w_inc = 1'b1;
    while (wb != 5'd31) begin
      rd_ptr_gray = gray(wb - 5'd2);
      tick();
      wb = wb + 5'd1;
      checks++;
      if (w_address !== wb[3:0] || full_flag !== 1'b0) begin
        failures++;
        $display("FAIL wrap_step addr=%0d full=%b exp addr=%0d full=0", w_address, full_flag, wb[3:0]);
      end
    end
    rd_ptr_gray = gray(wb - 5'd2);
    tick();
    w_inc = 1'b0;
    checks++;
    if (w_address !== 4'd0 || w_ptr_gray !== 5'b00000 || full_flag !== 1'b0) begin
      failures++;
      $display("FAIL wrap_zero addr=%0d gray=%b full=%b exp addr=0 gray=00000 full=0",
               w_address, w_ptr_gray, full_flag);
    end
  endtask

  task automatic test_held_request();
    do_reset();
    w_inc = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    checks++;
    if (full_flag !== 1'b1 || w_address !== 4'd0 || w_ptr_gray !== 5'b11000) begin
      failures++;
      $display("FAIL held_full full=%b addr=%0d gray=%b exp full=1 addr=0 gray=11000",
               full_flag, w_address, w_ptr_gray);
    end
    rd_ptr_gray = 5'b00001;
    tick();
    tick();
    checks++;
    if (full_flag !== 1'b1 || w_address !== 4'd0) begin
      failures++;
      $display("FAIL held_sync full=%b addr=%0d exp full=1 addr=0", full_flag, w_address);
    end
    tick();
    checks++;
    if (full_flag !== 1'b0 || w_address !== 4'd0 || w_level !== 5'd15) begin
      failures++;
      $display("FAIL held_free full=%b addr=%0d level=%0d exp full=0 addr=0 level=15",
               full_flag, w_address, w_level);
    end
    tick();
    checks++;
    if (full_flag !== 1'b1 || w_address !== 4'd1 || w_ptr_gray !== 5'b11001 || w_level !== 5'd16) begin
      failures++;
      $display("FAIL held_accept full=%b addr=%0d gray=%b level=%0d exp full=1 addr=1 gray=11001 level=16",
               full_flag, w_address, w_ptr_gray, w_level);
    end
    tick();
    tick();
    checks++;
    if (full_flag !== 1'b1 || w_address !== 4'd1) begin
      failures++;
      $display("FAIL held_once full=%b addr=%0d exp full=1 addr=1", full_flag, w_address);
    end
    w_inc = 1'b0;
  endtask

`ifdef FIFO_WR_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    w_inc = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (almost_full !== (k >= 12) || w_level !== 5'(k)) begin
        failures++;
        $display("FAIL af_fill_%0d af=%b level=%0d exp af=%b level=%0d",
                 k, almost_full, w_level, (k >= 12), k);
      end
    end
    w_inc       = 1'b0;
    rd_ptr_gray = gray(5'd1);
    tick();
    tick();
    checks++;
    if (almost_full !== 1'b1) begin
      failures++;
      $display("FAIL af_hold got=%b exp=1", almost_full);
    end
    tick();
    checks++;
    if (almost_full !== 1'b0 || w_level !== 5'd11) begin
      failures++;
      $display("FAIL af_drop af=%b level=%0d exp af=0 level=11", almost_full, w_level);
    end
  endtask
`endif

  initial begin
    w_rst_n     = 1'b0;
    w_inc       = 1'b0;
    rd_ptr_gray = 5'd0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_held_request();
`ifdef FIFO_WR_ALMOST_FULL_EN
    test_almost_full();
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
